// File: rtl/led_period_meter.sv
// led_period_meter
// Measures the rise-to-rise period and high time of an asynchronous square
// wave in clk cycles, flags when consecutive periods agree (locked) and when
// the input has stopped toggling long enough to saturate the counter (timeout).

module led_period_meter #(
  parameter int CNT_W = 16,
  parameter int TOL   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             blink_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             period_valid,
  output logic             locked,
  output logic             timeout
);

  typedef enum logic [0:0] {
    ST_WAIT_EDGE = 1'b0,
    ST_MEASURE   = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] ZERO_C = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] ONE_C  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] MAX_C  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] TOL_C  = CNT_W'(TOL);

  // Unsigned distance between two counts, never wraps.
  function automatic logic [CNT_W-1:0] abs_diff(input logic [CNT_W-1:0] a,
                                                input logic [CNT_W-1:0] b);
    logic [CNT_W-1:0] d;
    if (a >= b) begin
      d = a - b;
    end else begin
      d = b - a;
    end
    return d;
  endfunction

  logic             r_s1;
  logic             r_s2;
  logic             r_prev;
  state_t           r_state;
  state_t           w_next_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_hcnt;
  logic [CNT_W-1:0] r_period;
  logic [CNT_W-1:0] r_high_time;
  logic [CNT_W-1:0] r_prev_period;
  logic             r_have_prev;
  logic             r_period_valid;
  logic             r_locked;
  logic             r_timeout;

  logic             w_rise;
  logic             w_cnt_max;
  logic             w_start;
  logic             w_done;
  logic             w_tick;
  logic             w_to;
  logic             w_within_tol;

  // The falling edge is implied by s2 dropping; only the level of s2 is
  // needed for the high-time count, so no separate fall strobe is kept.
  assign w_rise       = r_s2 & ~r_prev;
  assign w_cnt_max    = (r_cnt == MAX_C);
  assign w_within_tol = (abs_diff(r_cnt, r_prev_period) <= TOL_C);

  // Two-flop synchroniser plus edge-history flop for blink_in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1   <= 1'b0;
      r_s2   <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_s1   <= blink_in;
      r_s2   <= r_s1;
      r_prev <= r_s2;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_WAIT_EDGE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // FSM next-state logic; a rise always wins over counter saturation.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_WAIT_EDGE: begin
        if (w_rise) begin
          w_next_state = ST_MEASURE;
        end else begin
          w_next_state = ST_WAIT_EDGE;
        end
      end
      ST_MEASURE: begin
        if (w_rise) begin
          w_next_state = ST_MEASURE;
        end else if (w_cnt_max) begin
          w_next_state = ST_WAIT_EDGE;
        end else begin
          w_next_state = ST_MEASURE;
        end
      end
      default: begin
        w_next_state = ST_WAIT_EDGE;
      end
    endcase
  end

  // FSM outputs: control strobes for the counters and result registers.
  always_comb begin
    w_start = 1'b0;
    w_done  = 1'b0;
    w_tick  = 1'b0;
    w_to    = 1'b0;
    case (r_state)
      ST_WAIT_EDGE: begin
        if (w_rise) begin
          w_start = 1'b1;
        end else begin
          w_start = 1'b0;
        end
      end
      ST_MEASURE: begin
        if (w_rise) begin
          w_done = 1'b1;
        end else if (w_cnt_max) begin
          w_to = 1'b1;
        end else begin
          w_tick = 1'b1;
        end
      end
      default: begin
        w_start = 1'b0;
      end
    endcase
  end

  // Period and high-time counters; the rise cycle itself counts as cycle 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt  <= ZERO_C;
      r_hcnt <= ZERO_C;
    end else if (w_start || w_done) begin
      r_cnt  <= ONE_C;
      r_hcnt <= ONE_C;
    end else if (w_tick) begin
      r_cnt <= r_cnt + ONE_C;
      if (r_s2) begin
        r_hcnt <= r_hcnt + ONE_C;
      end else begin
        r_hcnt <= r_hcnt;
      end
    end else begin
      r_cnt  <= r_cnt;
      r_hcnt <= r_hcnt;
    end
  end

  // Result capture, lock tracking and sticky timeout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_period       <= ZERO_C;
      r_high_time    <= ZERO_C;
      r_prev_period  <= ZERO_C;
      r_have_prev    <= 1'b0;
      r_period_valid <= 1'b0;
      r_locked       <= 1'b0;
      r_timeout      <= 1'b0;
    end else begin
      r_period_valid <= w_done;
      if (w_done) begin
        r_period      <= r_cnt;
        r_high_time   <= r_hcnt;
        r_prev_period <= r_cnt;
        r_have_prev   <= 1'b1;
        r_locked      <= r_have_prev & w_within_tol;
        r_timeout     <= 1'b0;
      end else if (w_to) begin
        r_have_prev   <= 1'b0;
        r_locked      <= 1'b0;
        r_timeout     <= 1'b1;
      end else begin
        r_have_prev   <= r_have_prev;
        r_locked      <= r_locked;
        r_timeout     <= r_timeout;
      end
    end
  end

  assign period       = r_period;
  assign high_time    = r_high_time;
  assign period_valid = r_period_valid;
  assign locked       = r_locked;
  assign timeout      = r_timeout;

endmodule

// File: tb/tb_led_period_meter.sv
// Directed testbench for led_period_meter: a 16-bit instance for period,
// high time, lock and reset behaviour, and an 8-bit instance for timeout.

module tb_led_period_meter;

  logic        clk;
  logic        rst;
  logic        blink;
  logic [15:0] period;
  logic [15:0] high_time;
  logic        period_valid;
  logic        locked;
  logic        timeout;

  logic        rst8;
  logic        blink8;
  logic [7:0]  period8;
  logic [7:0]  high8;
  logic        pv8;
  logic        locked8;
  logic        timeout8;

  int n_checks = 0;
  int n_fail   = 0;

  int   valid_cnt = 0;
  int   pv8_cnt   = 0;
  int   pv_double = 0;
  logic pv_last   = 1'b0;
  int   last_p    = 0;
  int   last_h    = 0;
  logic lock_hist [0:127];
  int   base;

  led_period_meter #(.CNT_W(16), .TOL(1)) dut (
    .clk          (clk),
    .rst          (rst),
    .blink_in     (blink),
    .period       (period),
    .high_time    (high_time),
    .period_valid (period_valid),
    .locked       (locked),
    .timeout      (timeout)
  );

  led_period_meter #(.CNT_W(8), .TOL(1)) dut8 (
    .clk          (clk),
    .rst          (rst8),
    .blink_in     (blink8),
    .period       (period8),
    .high_time    (high8),
    .period_valid (pv8),
    .locked       (locked8),
    .timeout      (timeout8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record each measurement pulse away from the active edge.
  always @(negedge clk) begin
    if (period_valid) begin
      if (valid_cnt < 128) lock_hist[valid_cnt] = locked;
      valid_cnt = valid_cnt + 1;
      last_p    = int'(period);
      last_h    = int'(high_time);
      if (pv_last) pv_double = pv_double + 1;
    end
    pv_last = period_valid;
    if (pv8) pv8_cnt = pv8_cnt + 1;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (obs !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic one_period(input int h, input int l);
    blink = 1'b1;
    repeat (h) tick();
    blink = 1'b0;
    repeat (l) tick();
  endtask

  task automatic one_period8(input int h, input int l);
    blink8 = 1'b1;
    repeat (h) tick();
    blink8 = 1'b0;
    repeat (l) tick();
  endtask

  initial begin
    rst = 1'b1; rst8 = 1'b1; blink = 1'b0; blink8 = 1'b0;
    repeat (3) tick();
    check_val("rst_period",    32'(period), 32'd0);
    check_val("rst_high",      32'(high_time), 32'd0);
    check_val("rst_valid",     32'(period_valid), 32'd0);
    check_val("rst_locked",    32'(locked), 32'd0);
    check_val("rst_timeout",   32'(timeout), 32'd0);
    check_val("rst8_period",   32'(period8), 32'd0);
    rst = 1'b0; rst8 = 1'b0;
    tick();

    // 8 high / 8 low: six rises give five measurements.
    base = valid_cnt;
    repeat (6) one_period(8, 8);
    check_val("sq_count",      32'(valid_cnt - base), 32'd5);
    check_val("sq_period",     32'(last_p), 32'd16);
    check_val("sq_high",       32'(last_h), 32'd8);
    check_val("sq_first_lock", 32'(lock_hist[base]), 32'd0);
    check_val("sq_second_lock",32'(lock_hist[base+1]), 32'd1);
    check_val("sq_locked",     32'(locked), 32'd1);

    // 4 high / 12 low: same period, shorter high time.
    base = valid_cnt;
    repeat (4) one_period(4, 12);
    check_val("duty_count",    32'(valid_cnt - base), 32'd4);
    check_val("duty_period",   32'(last_p), 32'd16);
    check_val("duty_high",     32'(last_h), 32'd4);
    check_val("duty_locked",   32'(locked), 32'd1);

    // Periods 16, 17, 19, 16: lock holds on diff 1, drops on diff 2 and 3.
    one_period(8, 9);
    check_val("p16_period",    32'(last_p), 32'd16);
    one_period(8, 11);
    check_val("p17_period",    32'(last_p), 32'd17);
    check_val("p17_locked",    32'(locked), 32'd1);
    one_period(8, 8);
    check_val("p19_period",    32'(last_p), 32'd19);
    check_val("p19_locked",    32'(locked), 32'd0);
    one_period(8, 8);
    check_val("p16b_period",   32'(last_p), 32'd16);
    check_val("p16b_locked",   32'(locked), 32'd0);
    one_period(8, 8);
    check_val("relock",        32'(locked), 32'd1);

    // Reset mid-period while locked.
    blink = 1'b1;
    repeat (4) tick();
    rst = 1'b1;
    #1;
    check_val("mid_rst_period",  32'(period), 32'd0);
    check_val("mid_rst_high",    32'(high_time), 32'd0);
    check_val("mid_rst_valid",   32'(period_valid), 32'd0);
    check_val("mid_rst_locked",  32'(locked), 32'd0);
    check_val("mid_rst_timeout", 32'(timeout), 32'd0);
    blink = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    base = valid_cnt;
    one_period(8, 8);
    check_val("post_rst_first",  32'(valid_cnt - base), 32'd0);
    one_period(8, 8);
    check_val("post_rst_second", 32'(valid_cnt - base), 32'd1);
    check_val("post_rst_period", 32'(last_p), 32'd16);

    // Input high at reset release.
    rst = 1'b1;
    blink = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    base = valid_cnt;
    repeat (8) tick();
    blink = 1'b0;
    repeat (8) tick();
    check_val("hi_rel_none",   32'(valid_cnt - base), 32'd0);
    one_period(8, 8);
    check_val("hi_rel_count",  32'(valid_cnt - base), 32'd1);
    check_val("hi_rel_period", 32'(last_p), 32'd16);

    // 8-bit instance: one rise then stuck low saturates the counter.
    one_period8(4, 200);
    check_val("to8_early",     32'(timeout8), 32'd0);
    repeat (100) tick();
    check_val("to8_set",       32'(timeout8), 32'd1);
    check_val("to8_locked",    32'(locked8), 32'd0);
    check_val("to8_period",    32'(period8), 32'd0);
    check_val("to8_no_valid",  32'(pv8_cnt), 32'd0);
    one_period8(4, 16);
    check_val("to8_sticky",    32'(timeout8), 32'd1);
    one_period8(4, 251);
    check_val("to8_p20",       32'(period8), 32'd20);
    check_val("to8_h4",        32'(high8), 32'd4);
    check_val("to8_cleared",   32'(timeout8), 32'd0);
    check_val("to8_valid_cnt", 32'(pv8_cnt), 32'd1);
    one_period8(4, 16);
    check_val("max8_period",   32'(period8), 32'd255);
    check_val("max8_timeout",  32'(timeout8), 32'd0);
    one_period8(4, 16);
    check_val("after_max_p",   32'(period8), 32'd20);
    check_val("after_max_lk",  32'(locked8), 32'd0);

    check_val("pv_width",      32'(pv_double), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
